multi_project_io_mux: RTL

//  Successor to the single-design user-area wrapper. Hosts NUM_PROJ designs (AS2650 variants,

---
 rtl/multi_project_io_mux_if.sv | 23 ++
 rtl/multi_project_io_mux.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multi_project_io_mux_if.sv
// Management Wishbone slave bus used to select the hosted design.
//   master: drives strobe/cycle/write-enable/selects/address/write data
//   slave : returns one-cycle ack and read data (zero when not acking)
interface multi_project_io_mux_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/multi_project_io_mux.sv
// Multi-project pad multiplexer. Hosts NUM_PROJ designs behind one pad ring and
// selects one at run time over the management Wishbone. A switch tri-states all
// pads for GUARD_CYCLES, then holds the incoming design in reset for RST_CYCLES,
// then hands it the pads. Non-selected designs are always held in reset.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wbs                : Wishbone slave (SEL 0x0, STATUS 0x4, CTRL 0x8, 0xC reads 0)
//   io_in/io_out/io_oeb: pad ring (oeb 1 = input)
//   proj_io_in         : io_in fanned out to every design
//   proj_io_out/oeb    : per-design pad drive, design k at [k*IO_PADS +: IO_PADS]
//   proj_rst           : per-design active-high reset
module multi_project_io_mux #(
  parameter int unsigned NUM_PROJ     = 4,
  parameter int unsigned IO_PADS      = 38,
  parameter int unsigned FIRST_PAD    = 5,
  parameter int unsigned GUARD_CYCLES = 8,
  parameter int unsigned RST_CYCLES   = 16,
  parameter logic [31:0] BASE_ADR     = 32'h3000_0000
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  multi_project_io_mux_if.slave        wbs,
  input  logic [IO_PADS-1:0]           io_in,
  output logic [IO_PADS-1:0]           io_out,
  output logic [IO_PADS-1:0]           io_oeb,
  output logic [IO_PADS-1:0]           proj_io_in,
  input  logic [NUM_PROJ*IO_PADS-1:0]  proj_io_out,
  input  logic [NUM_PROJ*IO_PADS-1:0]  proj_io_oeb,
  output logic [NUM_PROJ-1:0]          proj_rst
);

  localparam int unsigned MAXC = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    GUARD = 2'd1,
    RESET = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          active_q, active_d;
  logic [3:0]          target_q, target_d;
  logic [3:0]          sel_q, sel_d;
  logic [3:0]          pend_idx_q, pend_idx_d;
  logic                pend_q, pend_d;
  logic                err_q, err_d;
  logic                ack_q;
  logic [31:0]         dat_q, dat_d;
  logic [IO_PADS-1:0]  io_out_q, io_out_d;
  logic [IO_PADS-1:0]  io_oeb_q, io_oeb_d;
  logic [NUM_PROJ-1:0] proj_rst_q, proj_rst_d;

  logic        req, adr_hit, wr, wr_sel, wr_ctrl, idx_ok;
  logic [3:0]  wr_idx;
  logic [31:0] rd_data;

  assign proj_io_in    = io_in;
  assign io_out        = io_out_q;
  assign io_oeb        = io_oeb_q;
  assign proj_rst      = proj_rst_q;
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

  // Bus decode: every strobe is acked; only matching addresses with sel[0] write.
  always_comb begin
    req     = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
    adr_hit = (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    wr      = req & wbs.wbs_we_i & wbs.wbs_sel_i[0] & adr_hit;
    wr_sel  = wr & (wbs.wbs_adr_i[3:2] == 2'd0);
    wr_ctrl = wr & (wbs.wbs_adr_i[3:2] == 2'd2) & wbs.wbs_dat_i[0];
    wr_idx  = wbs.wbs_dat_i[3:0];
    idx_ok  = (32'(wr_idx) < NUM_PROJ);

    case (wbs.wbs_adr_i[3:2])
      2'd0:    rd_data = {28'd0, sel_q};
      2'd1:    rd_data = {22'd0, pend_q, err_q, 2'b00, state_q, active_q};
      default: rd_data = '0;
    endcase
    dat_d = (req & ~wbs.wbs_we_i & adr_hit) ? rd_data : '0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    active_d   = active_q;
    target_d   = target_q;
    sel_d      = sel_q;
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;
    err_d      = err_q;
    io_out_d   = '0;
    io_oeb_d   = '1;
    proj_rst_d = '1;

    if (wr_sel) begin
      err_d = ~idx_ok;
      if (idx_ok) sel_d = wr_idx;
    end

    case (state_q)
      BOOT, RESET: begin
        if (wr_sel && idx_ok) begin
          pend_d     = 1'b1;
          pend_idx_d = wr_idx;
        end
        if (cnt_q == RST_LAST) begin
          state_d  = RUN;
          cnt_d    = '0;
          active_d = target_q;
        end
      end
      GUARD: begin
        if (wr_sel && idx_ok) begin
          pend_d     = 1'b1;
          pend_idx_d = wr_idx;
        end
        if (cnt_q == GUARD_LAST) begin
          state_d = RESET;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        // A fresh SEL write supersedes a request left pending from the last switch.
        if (wr_sel && idx_ok) begin
          pend_d = 1'b0;
          if (wr_idx != active_q) begin
            target_d = wr_idx;
            state_d  = GUARD;
            cnt_d    = '0;
          end
        end else if (pend_q) begin
          pend_d = 1'b0;
          if (pend_idx_q != active_q) begin
            target_d = pend_idx_q;
            state_d  = GUARD;
            cnt_d    = '0;
          end
        end else if (wr_ctrl) begin
          target_d = active_q;
          state_d  = GUARD;
          cnt_d    = '0;
        end

        for (int unsigned k = 0; k < NUM_PROJ; k++) begin
          proj_rst_d[k] = (32'(active_q) != k);
          if (32'(active_q) == k) begin
            io_out_d = proj_io_out[k*IO_PADS +: IO_PADS];
            io_oeb_d = proj_io_oeb[k*IO_PADS +: IO_PADS];
          end
        end
        for (int unsigned i = 0; i < FIRST_PAD; i++) begin
          io_out_d[i] = 1'b0;
          io_oeb_d[i] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= RESET;
      cnt_q      <= '0;
      active_q   <= '0;
      target_q   <= '0;
      sel_q      <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      io_out_q   <= '0;
      io_oeb_q   <= '1;
      proj_rst_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      target_q   <= target_d;
      sel_q      <= sel_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      err_q      <= err_d;
      ack_q      <= req;
      dat_q      <= dat_d;
      io_out_q   <= io_out_d;
      io_oeb_q   <= io_oeb_d;
      proj_rst_q <= proj_rst_d;
    end
  end

endmodule
